uart_cmd_decoder: RTL

//  Host-command front end of the logic analyzer. Unloads bytes from the UART receiver, parses single-byte opcodes

---
 rtl/la_cmd_pkg.sv | 45 ++++
 rtl/uart_cmd_decoder_if.sv | 28 ++
 rtl/cmd_timeout_timer.sv | 30 +++
 rtl/uart_cmd_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/la_cmd_pkg.sv
// Shared opcodes, response bytes, FSM state encodings and config widths for the
// logic-analyzer host command decoder.
package la_cmd_pkg;

    localparam int MASK_W = 3;
    localparam int DIV_W  = 16;

    localparam logic [7:0] OP_MASK  = 8'h4D;
    localparam logic [7:0] OP_DIV   = 8'h44;
    localparam logic [7:0] OP_ARM   = 8'h41;
    localparam logic [7:0] OP_RST   = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_CMD_WAIT_EMPTY = 3'd1;
    localparam logic [2:0] ST_ARG_WAIT       = 3'd2;
    localparam logic [2:0] ST_ARG_WAIT_EMPTY = 3'd3;
    localparam logic [2:0] ST_EXECUTE        = 3'd4;
    localparam logic [2:0] ST_SEND_ACK       = 3'd5;

    typedef enum logic [2:0] {
        IDLE           = ST_IDLE,
        CMD_WAIT_EMPTY = ST_CMD_WAIT_EMPTY,
        ARG_WAIT       = ST_ARG_WAIT,
        ARG_WAIT_EMPTY = ST_ARG_WAIT_EMPTY,
        EXECUTE        = ST_EXECUTE,
        SEND_ACK       = ST_SEND_ACK
    } state_t;

    typedef struct packed {
        logic [MASK_W-1:0] mask;
        logic [DIV_W-1:0]  div;
    } cfg_t;

    // Number of argument bytes that follow each opcode.
    function automatic logic [1:0] arg_count(input logic [7:0] op);
        case (op)
            OP_MASK: return 2'd1;
            OP_DIV:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// UART RX unload handshake plus the ACK/NAK response handshake toward the TX arbiter.
// master = command decoder side, slave = UART receiver / TX arbiter side.
interface uart_cmd_decoder_if;
    logic       UART_rxempty;
    logic [7:0] UART_rx_data;
    logic       UART_uld_rx_data;
    logic       ack_ready;
    logic       ack_valid;
    logic [7:0] ack_data;

    modport master (
        input  UART_rxempty,
        input  UART_rx_data,
        output UART_uld_rx_data,
        input  ack_ready,
        output ack_valid,
        output ack_data
    );

    modport slave (
        output UART_rxempty,
        output UART_rx_data,
        input  UART_uld_rx_data,
        output ack_ready,
        input  ack_valid,
        input  ack_data
    );
endinterface

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout counter: clear wins over enable, expired holds once reached.
// Latency: expired rises TIMEOUT_CYCLES-1 enabled cycles after the last clear; no backpressure.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses host opcodes from the UART RX buffer, updates capture config, answers each command with ACK/NAK.
// Latency: ~3 cycles byte-to-pulse; RX bytes stay unconsumed while a response waits for ack_ready.
module uart_cmd_decoder
    import la_cmd_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 5_000_000,
    parameter logic [MASK_W-1:0] MASK_RESET     = 3'b111,
    parameter logic [DIV_W-1:0]  DIV_RESET      = 16'd1
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_cmd_decoder_if.master  bus,
    input  logic                capture_active,
    output logic [MASK_W-1:0]   trigger_mask,
    output logic [DIV_W-1:0]    sample_div,
    output logic                arm_pulse,
    output logic                capture_rst_pulse,
    output logic                busy,
    output logic [7:0]          error_count,
    output logic [2:0]          state_debug
);

    state_t      state;
    logic [7:0]  opcode;
    logic [15:0] args;
    logic [1:0]  args_left;
    logic        uld_q;
    logic        ack_valid_q;
    logic [7:0]  ack_data_q;
    cfg_t        cfg;

    logic expired;
    logic count_en;
    logic timed_out;
    logic byte_accept;
    logic exec_ok;
    logic do_mask;
    logic do_div;
    logic do_arm;
    logic do_rst;
    logic err_inc;

    assign count_en    = (state == CMD_WAIT_EMPTY) || (state == ARG_WAIT) || (state == ARG_WAIT_EMPTY);
    assign timed_out   = count_en && expired;
    assign byte_accept = ((state == IDLE) || (state == ARG_WAIT)) && !bus.UART_rxempty && !timed_out;

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (byte_accept || !count_en),
        .enable  (count_en),
        .expired (expired)
    );

    // Command legality; only meaningful while in EXECUTE.
    always_comb begin
        do_mask = 1'b0;
        do_div  = 1'b0;
        do_arm  = 1'b0;
        do_rst  = 1'b0;
        case (opcode)
            OP_MASK: do_mask = !capture_active;
            OP_DIV:  do_div  = !capture_active && (args != 16'h0000);
            OP_ARM:  do_arm  = !capture_active;
            OP_RST:  do_rst  = 1'b1;
            default: ;
        endcase
        exec_ok = do_mask || do_div || do_arm || do_rst;
        err_inc = timed_out || ((state == EXECUTE) && !exec_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            opcode            <= 8'h00;
            args              <= 16'h0000;
            args_left         <= 2'd0;
            uld_q             <= 1'b0;
            ack_valid_q       <= 1'b0;
            ack_data_q        <= 8'h00;
            arm_pulse         <= 1'b0;
            capture_rst_pulse <= 1'b0;
        end else begin
            uld_q             <= 1'b0;
            arm_pulse         <= 1'b0;
            capture_rst_pulse <= 1'b0;
            if (timed_out) begin
                ack_data_q  <= NAK_BYTE;
                ack_valid_q <= 1'b1;
                state       <= SEND_ACK;
            end else begin
                case (state)
                    IDLE: begin
                        if (byte_accept) begin
                            opcode <= bus.UART_rx_data;
                            uld_q  <= 1'b1;
                            state  <= CMD_WAIT_EMPTY;
                        end
                    end
                    CMD_WAIT_EMPTY: begin
                        if (bus.UART_rxempty) begin
                            args_left <= arg_count(opcode);
                            state     <= (arg_count(opcode) == 2'd0) ? EXECUTE : ARG_WAIT;
                        end
                    end
                    ARG_WAIT: begin
                        if (byte_accept) begin
                            args      <= {args[7:0], bus.UART_rx_data};
                            args_left <= args_left - 2'd1;
                            uld_q     <= 1'b1;
                            state     <= ARG_WAIT_EMPTY;
                        end
                    end
                    ARG_WAIT_EMPTY: begin
                        if (bus.UART_rxempty) begin
                            state <= (args_left == 2'd0) ? EXECUTE : ARG_WAIT;
                        end
                    end
                    EXECUTE: begin
                        ack_data_q        <= exec_ok ? ACK_BYTE : NAK_BYTE;
                        ack_valid_q       <= 1'b1;
                        arm_pulse         <= do_arm;
                        capture_rst_pulse <= do_rst;
                        state             <= SEND_ACK;
                    end
                    SEND_ACK: begin
                        if (ack_valid_q && bus.ack_ready) begin
                            ack_valid_q <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.mask <= MASK_RESET;
            cfg.div  <= DIV_RESET;
        end else if (state == EXECUTE) begin
            if (do_mask) cfg.mask <= args[MASK_W-1:0];
            if (do_div)  cfg.div  <= args;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_count <= 8'h00;
        end else if (err_inc && (error_count != 8'hFF)) begin
            error_count <= error_count + 8'h01;
        end
    end

    assign bus.UART_uld_rx_data = uld_q;
    assign bus.ack_valid        = ack_valid_q;
    assign bus.ack_data         = ack_data_q;
    assign trigger_mask         = cfg.mask;
    assign sample_div           = cfg.div;
    assign busy                 = (state != IDLE);
    assign state_debug          = state;

endmodule
